// File: rtl/spi_ram_responder.sv
// SPI mode-0 target emulating a small serial SRAM (READ 0x03 / WRITE 0x02), all inputs oversampled on clk.
// Build with SPI_RAM_SEQ_EN for sequential (auto-increment) mode; otherwise one data byte per frame.
module spi_ram_responder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy,
  output logic wr_pulse,
  output logic cmd_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR_HI, ADDR_LO, READ, WRITE, IGNORE} state_e;

  state_e              state_q, state_d;
  logic                cs_meta_q, cs_s_q;
  logic                sck_meta_q, sck_s_q, sck_dly_q;
  logic                mosi_meta_q, mosi_s_q;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          rx_q, rx_d;
  logic [7:0]          tx_q, tx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                miso_q, miso_d;
  logic                cmd_err_q, cmd_err_d;
  logic                wr_pulse_q, wr_pulse_d;
  logic                mem_we;
  logic [7:0]          mem_q [DEPTH];

  logic       sck_rise, sck_fall, byte_done;
  logic [7:0] rx_byte;

  assign sck_rise  = sck_s_q & ~sck_dly_q;
  assign sck_fall  = ~sck_s_q & sck_dly_q;
  assign rx_byte   = {rx_q[6:0], mosi_s_q};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7) && (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_q   <= 1'b1;
      cs_s_q      <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_s_q     <= 1'b0;
      sck_dly_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      cs_meta_q   <= spi_cs_n;
      cs_s_q      <= cs_meta_q;
      sck_meta_q  <= spi_sck;
      sck_s_q     <= sck_meta_q;
      sck_dly_q   <= sck_s_q;
      mosi_meta_q <= spi_mosi;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      miso_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      wr_pulse_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      miso_q     <= miso_d;
      cmd_err_q  <= cmd_err_d;
      wr_pulse_q <= wr_pulse_d;
      if (mem_we) mem_q[addr_q] <= rx_byte;
    end
  end

  // A pending SCK rise is still honoured in the cycle CS deasserts, so a final byte commits.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    miso_d     = miso_q;
    cmd_err_d  = cmd_err_q;
    wr_pulse_d = 1'b0;
    mem_we     = 1'b0;
    if (state_q == IDLE) begin
      miso_d = 1'b0;
      if (!cs_s_q) begin
        state_d   = CMD;
        bit_cnt_d = '0;
        cmd_err_d = 1'b0;
      end
    end else begin
      if (sck_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        case (state_q)
          CMD: begin
            if (rx_byte == 8'h03) begin
              rd_d    = 1'b1;
              state_d = ADDR_HI;
            end else if (rx_byte == 8'h02) begin
              rd_d    = 1'b0;
              state_d = ADDR_HI;
            end else begin
              cmd_err_d = 1'b1;
              state_d   = IGNORE;
            end
          end
          ADDR_HI: state_d = ADDR_LO;
          ADDR_LO: begin
            addr_d = rx_byte[ADDR_W-1:0];
            if (rd_q) begin
              tx_d    = mem_q[rx_byte[ADDR_W-1:0]];
              state_d = READ;
            end else begin
              state_d = WRITE;
            end
          end
          READ: begin
`ifdef SPI_RAM_SEQ_EN
            addr_d = addr_q + 1'b1;
            tx_d   = mem_q[addr_q + 1'b1];
`else
            state_d = IGNORE;
`endif
          end
          WRITE: begin
            mem_we     = 1'b1;
            wr_pulse_d = 1'b1;
`ifdef SPI_RAM_SEQ_EN
            addr_d = addr_q + 1'b1;
`else
            state_d = IGNORE;
`endif
          end
          default: ;
        endcase
      end
      if (state_q == READ && sck_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (state_q != READ) miso_d = 1'b0;
      if (cs_s_q) state_d = IDLE;
    end
  end

  assign spi_miso = miso_q & (state_q == READ);
  assign busy     = ~cs_s_q;
  assign wr_pulse = wr_pulse_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Randomized bench for spi_ram_responder: an SPI initiator plus a byte-array memory model of the SRAM.
`timescale 1ns/1ps
module tb_spi_ram_responder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef SPI_RAM_SEQ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic spi_cs_n = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, busy, wr_pulse, cmd_err;

  int n_chk = 0, n_fail = 0;
  int wr_cnt = 0, miso_hi_cnt = 0;
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] dbuf [8];
  logic [7:0] rbuf [8];

  spi_ram_responder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy),
    .wr_pulse(wr_pulse), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (wr_pulse === 1'b1) wr_cnt++;
  always @(negedge clk) if (!spi_cs_n && spi_miso !== 1'b0) miso_hi_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Initiator samples MISO just before each SCK rise; SCK half period is 4 clk.
  task automatic xfer_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [7:0] op, input logic [15:0] a, input int n, input string tag);
    int w0, m0, idx, pulses;
    logic [7:0] r0, r1, r2, e;
    bit known;
    known = (op == 8'h02) || (op == 8'h03);
    w0 = wr_cnt;
    m0 = miso_hi_cnt;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_busy1"}, 32'(busy), 32'd1);
    chk({tag, "_errclr"}, 32'(cmd_err), 32'd0);
    xfer_bits(op, 8, r0);
    xfer_bits(a[15:8], 8, r1);
    xfer_bits(a[7:0], 8, r2);
    chk({tag, "_hdrmiso"}, 32'(r0 | r1 | r2), 32'd0);
    for (int k = 0; k < n; k++) xfer_bits(dbuf[k], 8, rbuf[k]);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    idx = int'(a[AW-1:0]);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      if (op == 8'h03) begin
        e = (SEQ || k == 0) ? ref_mem[(idx + k) % DEPTH] : 8'h00;
        chk($sformatf("%s_rd%0d", tag, k), 32'(rbuf[k]), 32'(e));
      end else if (op == 8'h02 && (SEQ || k == 0)) begin
        ref_mem[(idx + k) % DEPTH] = dbuf[k];
        pulses++;
      end
    end
    chk({tag, "_wrpulses"}, 32'(wr_cnt - w0), 32'(pulses));
    chk({tag, "_cmderr"}, 32'(cmd_err), 32'(!known));
    chk({tag, "_busy0"}, 32'(busy), 32'd0);
    if (!known) chk({tag, "_misoquiet"}, 32'(miso_hi_cnt - m0), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    int w0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wrp", 32'(wr_pulse), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    dbuf[0] = 8'hA5;
    do_frame(8'h02, 16'h0005, 1, "wr05");
    dbuf[0] = 8'h00;
    do_frame(8'h03, 16'h0005, 1, "rd05");

    dbuf[0] = 8'h11; dbuf[1] = 8'h22;
    do_frame(8'h02, 16'h000F, 2, "wrwrap");
    do_frame(8'h03, 16'h000F, 2, "rdwrap");

    dbuf[0] = 8'h33; dbuf[1] = 8'h44;
    do_frame(8'h02, 16'h0003, 2, "wr03");
    do_frame(8'h03, 16'h0003, 2, "rd03");
    do_frame(8'h03, 16'h0004, 1, "rd04");

    dbuf[0] = 8'h5A; dbuf[1] = 8'hFF;
    do_frame(8'h9F, 16'h0002, 2, "op9f");

    // Write header plus a truncated data byte must not commit anything.
    w0 = wr_cnt;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    xfer_bits(8'h02, 8, r);
    xfer_bits(8'h00, 8, r);
    xfer_bits(8'h07, 8, r);
    xfer_bits(8'hC8, 5, r);
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("part_busy", 32'(busy), 32'd0);
    chk("part_wrp", 32'(wr_cnt - w0), 32'd0);
    do_frame(8'h03, 16'h0007, 1, "part_rd07");

    for (int t = 0; t < 30; t++) begin
      logic [7:0] op;
      case ($urandom_range(0, 4))
        0, 1:    op = 8'h02;
        2, 3:    op = 8'h03;
        default: op = 8'($urandom);
      endcase
      for (int k = 0; k < 4; k++) dbuf[k] = 8'($urandom);
      do_frame(op, 16'($urandom), $urandom_range(1, 4), $sformatf("rnd%0d", t));
    end

    dbuf[0] = 8'hE7;
    do_frame(8'h02, 16'h0005, 1, "pre_rst_wr");
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    xfer_bits(8'h03, 8, r);
    xfer_bits(8'h00, 8, r);
    xfer_bits(8'h05, 8, r);
    xfer_bits(8'h00, 3, r);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_miso", 32'(spi_miso), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(cmd_err), 32'd0);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    repeat (4) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) do_frame(8'h03, 16'(i), 1, $sformatf("clr%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
